// File: rtl/ising_config.sv
// Shared constants and types for the Ising machine front-end blocks.
package ising_config;

  localparam int unsigned ADC_SAMPLE_W    = 16;
  localparam int unsigned ADC_NUM_SAMPLES = 16;
  localparam int unsigned ADC_WORD_W      = ADC_SAMPLE_W * ADC_NUM_SAMPLES;
  localparam int unsigned ADC_SUM_W       = 20;
  localparam int unsigned ADC_ACC_W       = 29;
  localparam int unsigned ADC_RES_W       = 32;
  localparam int unsigned GPIO_W          = 32;
  localparam int unsigned GPIO_ADDR_W     = 16;
  localparam int unsigned GPIO_DATA_W     = 8;

  localparam logic [15:0] ADC_SHIFT_OFS  = 16'd0;
  localparam logic [15:0] ADC_DLY_LO_OFS = 16'd1;
  localparam logic [15:0] ADC_DLY_HI_OFS = 16'd2;
  localparam logic [15:0] ADC_NWORDS_OFS = 16'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } adc_rd_state_t;

  // Field layout of the shared configuration bus.
  typedef struct packed {
    logic [6:0]             rsvd;
    logic                   wclk;
    logic [GPIO_DATA_W-1:0] data;
    logic [GPIO_ADDR_W-1:0] addr;
  } gpio_bus_t;

endpackage

// File: rtl/config_reg.sv
// Byte-addressed configuration register; byte k lives at ADDR+k.
module config_reg #(
  parameter logic [15:0] ADDR   = 16'h0000,
  parameter int unsigned NBYTES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_stb,
  input  logic [15:0]         i_addr,
  input  logic [7:0]          i_data,
  output logic [8*NBYTES-1:0] o_value
);

  localparam int unsigned W = 8 * NBYTES;

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
    end else if (i_wr_stb) begin
      for (int k = 0; k < int'(NBYTES); k++) begin
        if (i_addr == 16'(ADDR + 16'(k))) begin
          r_value[8*k +: 8] <= i_data;
        end
      end
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/input_aligner.sv
// Two-stage ADC pipeline: sample realignment across word boundary, then word sum.
module input_aligner
  import ising_config::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADC_WORD_W-1:0]       i_adc,
  input  logic [3:0]                  i_shift,
  output logic signed [ADC_SUM_W-1:0] o_word_sum
);

  logic [ADC_WORD_W-1:0]       r_prev;
  logic [ADC_WORD_W-1:0]       r_aligned;
  logic signed [ADC_SUM_W-1:0] r_word_sum;
  logic [2*ADC_WORD_W-1:0]     w_cat;
  logic [ADC_WORD_W-1:0]       w_aligned;
  logic [8:0]                  w_bit_ofs;
  logic signed [ADC_SUM_W-1:0] w_sum;

  // Older word sits in the low half, so shift 0 selects prev untouched.
  assign w_cat     = {i_adc, r_prev};
  assign w_bit_ofs = 9'(i_shift) * 9'(ADC_SAMPLE_W);
  assign w_aligned = w_cat[w_bit_ofs +: ADC_WORD_W];

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(ADC_NUM_SAMPLES); i++) begin
      w_sum = w_sum + ADC_SUM_W'($signed(r_aligned[i*ADC_SAMPLE_W +: ADC_SAMPLE_W]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev     <= '0;
      r_aligned  <= '0;
      r_word_sum <= '0;
    end else begin
      r_prev     <= i_adc;
      r_aligned  <= w_aligned;
      r_word_sum <= w_sum;
    end
  end

  assign o_word_sum = r_word_sum;

endmodule

// File: rtl/adc_reader.sv
// ADC measurement block: triggered delay, then signed sum of aligned ADC words.
module adc_reader
  import ising_config::*;
#(
  parameter logic [15:0] base_addr = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_W-1:0]     gpio_in,
  input  logic [ADC_WORD_W-1:0] adc_in,
  input  logic                  fsm_trig_in,
  output logic                  busy_out,
  output logic [ADC_RES_W-1:0]  result_out,
  output logic                  result_valid_out
);

  localparam int unsigned DLY_BYTES = int'(ADC_DLY_HI_OFS - ADC_DLY_LO_OFS) + 1;
  localparam int unsigned WCNT_W    = 9;

  gpio_bus_t                   w_gpio;
  logic [2:0]                  r_wclk_sync;
  logic                        w_wr_stb;
  logic [7:0]                  w_shift_cfg;
  logic [8*DLY_BYTES-1:0]      w_dly_cfg;
  logic [7:0]                  w_nwords_cfg;
  logic                        w_unused;

  adc_rd_state_t               r_state;
  adc_rd_state_t               w_state_nxt;
  logic [3:0]                  r_shift_sh;
  logic [7:0]                  r_nwords_sh;
  logic [15:0]                 r_dly_cnt;
  logic [WCNT_W-1:0]           r_wcnt;
  logic [WCNT_W-1:0]           w_nlast;
  logic signed [ADC_ACC_W-1:0] r_acc;
  logic signed [ADC_SUM_W-1:0] w_word_sum;
  logic [ADC_RES_W-1:0]        r_result;
  logic                        r_valid;
  logic                        r_busy;
  logic                        w_load;
  logic                        w_acc_clr;
  logic                        w_acc_en;
  logic                        w_done;

  assign w_gpio   = gpio_bus_t'(gpio_in);
  assign w_unused = &{1'b0, w_gpio.rsvd, w_shift_cfg[7:4]};

  // Write clock is asynchronous to clk: two sync flops plus one for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wclk_sync <= '0;
    end else begin
      r_wclk_sync <= {r_wclk_sync[1:0], w_gpio.wclk};
    end
  end

  assign w_wr_stb = r_wclk_sync[1] & ~r_wclk_sync[2];

  config_reg #(.ADDR(16'(base_addr + ADC_SHIFT_OFS)), .NBYTES(1)) u_cfg_shift (
    .clk      (clk),
    .rst      (rst),
    .i_wr_stb (w_wr_stb),
    .i_addr   (w_gpio.addr),
    .i_data   (w_gpio.data),
    .o_value  (w_shift_cfg)
  );

  config_reg #(.ADDR(16'(base_addr + ADC_DLY_LO_OFS)), .NBYTES(DLY_BYTES)) u_cfg_delay (
    .clk      (clk),
    .rst      (rst),
    .i_wr_stb (w_wr_stb),
    .i_addr   (w_gpio.addr),
    .i_data   (w_gpio.data),
    .o_value  (w_dly_cfg)
  );

  config_reg #(.ADDR(16'(base_addr + ADC_NWORDS_OFS)), .NBYTES(1)) u_cfg_nwords (
    .clk      (clk),
    .rst      (rst),
    .i_wr_stb (w_wr_stb),
    .i_addr   (w_gpio.addr),
    .i_data   (w_gpio.data),
    .o_value  (w_nwords_cfg)
  );

  input_aligner u_align (
    .clk        (clk),
    .rst        (rst),
    .i_adc      (adc_in),
    .i_shift    (r_shift_sh),
    .o_word_sum (w_word_sum)
  );

  // ACCUM spans N+2 cycles; the first two cover the aligner pipeline fill.
  assign w_nlast = (r_nwords_sh == 8'd0) ? WCNT_W'(257) : WCNT_W'(r_nwords_sh) + WCNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (fsm_trig_in) begin
          w_load = 1'b1;
          if (w_dly_cfg == 16'd0) begin
            w_state_nxt = ACCUM;
            w_acc_clr   = 1'b1;
          end else begin
            w_state_nxt = DELAY;
          end
        end
      end
      DELAY: begin
        if (r_dly_cnt == 16'd1) begin
          w_state_nxt = ACCUM;
          w_acc_clr   = 1'b1;
        end
      end
      ACCUM: begin
        w_acc_en = (r_wcnt >= WCNT_W'(2));
        if (r_wcnt == w_nlast) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift_sh  <= '0;
      r_nwords_sh <= '0;
      r_dly_cnt   <= '0;
      r_wcnt      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_load) begin
        r_shift_sh  <= w_shift_cfg[3:0];
        r_nwords_sh <= w_nwords_cfg;
        r_dly_cnt   <= w_dly_cfg;
        r_busy      <= 1'b1;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
      if (r_state == DELAY) begin
        r_dly_cnt <= r_dly_cnt - 16'd1;
      end
      if (w_acc_clr) begin
        r_wcnt <= '0;
        r_acc  <= '0;
      end else if (r_state == ACCUM) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
        if (w_acc_en) begin
          r_acc <= r_acc + ADC_ACC_W'(w_word_sum);
        end
      end
      if (w_done) begin
        r_result <= ADC_RES_W'(r_acc);
      end
    end
  end

  assign busy_out         = r_busy;
  assign result_out       = r_result;
  assign result_valid_out = r_valid;

endmodule

// File: doc/adc_reader.md
Name: adc_reader

Overview:
- Receive-side counterpart of the DAC output path: captures the 256-bit ADC sample word (16 signed 16-bit samples per clk) and realigns it by a programmable sample offset.
- On an FSM trigger, waits a programmable delay, sums all samples over a programmable number of words, and returns one signed 32-bit measurement to the Ising FSM.
- Configured over the shared 32-bit GPIO bus: 15:0 addr, 23:16 data, 24 w_clk.

Parameters:
- base_addr, 0, GPIO address of register 0. Registers are base_addr+0 … base_addr+3.
- sample_w, 16, bits per ADC sample. Fixed at 16.
- num_samples, 16, samples per ADC word. Fixed at 16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- gpio_in  in  32  config bus: 15:0 addr, 23:16 data, 24 w_clk
- adc_in  in  256  ADC word, sample i at bits [16i+15:16i], sample 0 oldest; valid every cycle
- fsm_trig_in  in  1  start measurement, single-cycle pulse
- busy_out  out  1  high from the cycle after an accepted trigger until result_valid_out
- result_out  out  32  signed accumulated sum
- result_valid_out  out  1  one-cycle pulse when result_out is updated

Behaviour:
- Reset (rst=0, async):
  - all config registers = 0; FSM = IDLE
  - busy_out=0, result_out=0, result_valid_out=0
  - pipeline registers cleared.
- GPIO write:
  - Synchronise gpio_in[24] with 2 flops; a rising edge is a write strobe.
  - On the strobe, if addr matches, latch data[7:0]:
    - +0: shift_amt[3:0]; upper bits ignored
    - +1: delay[7:0]
    - +2: delay[15:8]
    - +3: num_words[7:0], where 0 means 256
  - Non-matching addresses are ignored.
- Alignment, stage 1:
  - prev <= adc_in.
  - aligned = {adc_in, prev}[16*shift_amt +: 256]; shift_amt=0 gives prev unchanged.
  - Registered.
- Sum, stage 2:
  - word_sum = signed sum of the 16 aligned samples, 20 bits, registered.
- Accumulator: 29-bit signed, sign-extended to 32 bits on output. No overflow is possible.
- Config shadowing: shift_amt, delay and num_words are copied into shadow registers when a trigger is accepted. GPIO writes while busy take effect at the next trigger.
- FSM states:
  - IDLE: when fsm_trig_in=1, load the shadows and go to DELAY; if shadow delay=0, go straight to ACCUM.
  - DELAY: count down delay cycles, then go to ACCUM.
  - ACCUM: add word_sum for num_words consecutive cycles. The accumulator is cleared on entry. Then go to DONE.
  - DONE: result_out <= acc; result_valid_out=1 for one cycle; go to IDLE.
- Word selection and latency:
  - With the trigger seen at edge T, the accumulated words are those whose adc_in (cur half) was presented at edges T+delay+1 … T+delay+N.
  - Pipeline latency is compensated internally.
  - result_valid_out asserts at edge T+delay+N+3 exactly.
- Triggers while busy (DELAY/ACCUM/DONE) are ignored and not queued.
- A trigger in the same cycle as DONE is ignored; a new trigger is accepted from the IDLE cycle onward.
- result_out holds its value until the next DONE.
- rst asserted mid-measurement aborts immediately: outputs return to reset values and no valid pulse is produced.
- delay counter is 16 bits; delay=0xFFFF waits 65535 cycles. No wrap.

Decomposition:
- ising_config package holds:
  - ADC_SAMPLE_W=16, ADC_NUM_SAMPLES=16, ADC_WORD_W=256
  - typedef enum adc_rd_state_t {IDLE, DELAY, ACCUM, DONE}
  - register offset constants ADC_SHIFT_OFS=0, ADC_DLY_LO_OFS=1, ADC_DLY_HI_OFS=2, ADC_NWORDS_OFS=3
- Config registers use the existing config_reg block: one instance for shift_amt, a 2-byte instance for delay, one for num_words.
- Sub-module input_aligner holds stages 1-2 (prev register, barrel select, adder tree); it is pure pipeline.

Test Plan:
- Reset/defaults: hold rst=0 mid-run → busy_out=0, result_out=0, result_valid_out=0. Release, write nothing, trigger with adc_in all 0x0001 → num_words=0 means 256 words, result = 16*256 = 4096 at T+259.
- Basic sum: shift=0, delay=0, N=4, all samples 0x0010 → result_out=1024, valid at exactly T+7, busy high T+1..T+7.
- Alignment: shift=3, N=1, delay=0. Word at T+0 has samples 0..15 (value = index); word at T+1 has samples 16..31 (value = 16+index). Result = sum(3..18) = 168.
- Negative/full-scale: all samples 0x8000, num_words=0 → result_out=0xF8000000 (−134217728).
- Delay/shadowing: delay=0x0102 and N=2 written via GPIO (w_clk toggled per byte) → valid at T+263. A GPIO write of N=8 mid-run is unaffected in this run and applies to the next trigger.
- Busy rules: retrigger at T+3 and in the DONE cycle → ignored, exactly one valid pulse. Assert rst during ACCUM → no valid pulse, outputs are 0, and a new trigger works normally.
